// File: rtl/decoder_scan_seq.sv
// Registered 1-of-2^SEL_W active-low decoder with three-pin enable gating,
// direct or auto-scan line selection, and break-before-make dead time on every switch.
module decoder_scan_seq #(
    parameter int SEL_W       = 3,
    parameter int DWELL_W     = 16,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    Clock,
    input  logic                    ResetB,
    input  logic                    EnableB0,
    input  logic                    EnableB1,
    input  logic                    Enable2,
    input  logic                    Mode,
    input  logic [SEL_W-1:0]        SelectIn,
    input  logic [SEL_W-1:0]        ScanLast,
    input  logic [DWELL_W-1:0]      DwellCount,
    output logic [(1<<SEL_W)-1:0]   DecodedOut,
    output logic [SEL_W-1:0]        ActiveIndex,
    output logic                    ScanWrap,
    output logic [1:0]              state_dbg
);
    localparam int OUT_W  = 1 << SEL_W;
    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    active_q, active_d;
    logic [SEL_W-1:0]    pend_q, pend_d;
    logic                pend_wrap_q, pend_wrap_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic                mode_q;
    logic                wrap_q, wrap_d;
    logic [OUT_W-1:0]    dec_q, dec_d;

    logic                enabled;
    logic                mode_chg;
    logic                scan_wraps;
    logic [SEL_W-1:0]    scan_next;
    logic                start_sw;
    logic [SEL_W-1:0]    sw_idx;
    logic                sw_wrap;

    assign enabled    = EnableB0 & EnableB1 & ~Enable2;
    assign mode_chg   = Mode != mode_q;
    assign scan_wraps = active_q >= ScanLast;
    assign scan_next  = scan_wraps ? '0 : active_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_wrap_d = pend_wrap_q;
        dwell_d     = dwell_q;
        dead_d      = dead_q;
        wrap_d      = 1'b0;
        start_sw    = 1'b0;
        sw_idx      = '0;
        sw_wrap     = 1'b0;

        if (!enabled) begin
            state_d = IDLE;
            dwell_d = '0;
            dead_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = DRIVE;
                    active_d = Mode ? '0 : SelectIn;
                    dwell_d  = '0;
                end
                DRIVE: begin
                    if (mode_chg) begin
                        start_sw = 1'b1;
                        sw_idx   = Mode ? '0 : SelectIn;
                    end else if (!Mode) begin
                        if (SelectIn != active_q) begin
                            start_sw = 1'b1;
                            sw_idx   = SelectIn;
                        end
                    end else if (dwell_q >= DwellCount) begin
                        // A single-line scan (wrap back onto the same line) just restarts the dwell.
                        if (scan_next == active_q) begin
                            dwell_d = '0;
                            wrap_d  = scan_wraps;
                        end else begin
                            start_sw = 1'b1;
                            sw_idx   = scan_next;
                            sw_wrap  = scan_wraps;
                        end
                    end else begin
                        dwell_d = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;
                    end
                end
                DEAD: begin
                    if (mode_chg) begin
                        pend_d      = Mode ? '0 : SelectIn;
                        pend_wrap_d = 1'b0;
                        dwell_d     = '0;
                    end else if (!Mode) begin
                        pend_d      = SelectIn;
                        pend_wrap_d = 1'b0;
                    end
                    if (dead_q == DEAD_LAST) begin
                        state_d  = DRIVE;
                        active_d = pend_d;
                        wrap_d   = pend_wrap_d;
                        dwell_d  = '0;
                        dead_d   = '0;
                    end else begin
                        dead_d = dead_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (start_sw) begin
                dwell_d = '0;
                if (DEAD_CYCLES == 0) begin
                    active_d = sw_idx;
                    wrap_d   = sw_wrap;
                end else begin
                    state_d     = DEAD;
                    pend_d      = sw_idx;
                    pend_wrap_d = sw_wrap;
                    dead_d      = '0;
                end
            end
        end

        // Output is decoded from the next state so the line register never shows two lows.
        dec_d = (state_d == DRIVE) ? ~(OUT_W'(1) << active_d) : '1;
    end

    always_ff @(posedge Clock or negedge ResetB) begin
        if (!ResetB) begin
            state_q     <= IDLE;
            active_q    <= '0;
            pend_q      <= '0;
            pend_wrap_q <= 1'b0;
            dwell_q     <= '0;
            dead_q      <= '0;
            mode_q      <= 1'b0;
            wrap_q      <= 1'b0;
            dec_q       <= '1;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_wrap_q <= pend_wrap_d;
            dwell_q     <= dwell_d;
            dead_q      <= dead_d;
            mode_q      <= Mode;
            wrap_q      <= wrap_d;
            dec_q       <= dec_d;
        end
    end

    assign DecodedOut  = dec_q;
    assign ActiveIndex = active_q;
    assign ScanWrap    = wrap_q;
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq: two instances (dead time 2 and 0) on shared stimulus,
// checked every cycle against a line/gap/age model plus directed literal expectations.
module tb_decoder_scan_seq;
    localparam int SEL_W = 3;
    localparam int DWELL_W = 16;

    logic               Clock;
    logic               ResetB;
    logic               EnableB0, EnableB1, Enable2, Mode;
    logic [SEL_W-1:0]   SelectIn, ScanLast;
    logic [DWELL_W-1:0] DwellCount;

    logic [7:0]       dec_a, dec_b;
    logic [SEL_W-1:0] idx_a, idx_b;
    logic             wrap_a, wrap_b;
    logic [1:0]       st_a, st_b;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;

    decoder_scan_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .DEAD_CYCLES(2)) dut_a (
        .Clock(Clock), .ResetB(ResetB), .EnableB0(EnableB0), .EnableB1(EnableB1),
        .Enable2(Enable2), .Mode(Mode), .SelectIn(SelectIn), .ScanLast(ScanLast),
        .DwellCount(DwellCount), .DecodedOut(dec_a), .ActiveIndex(idx_a),
        .ScanWrap(wrap_a), .state_dbg(st_a)
    );

    decoder_scan_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .DEAD_CYCLES(0)) dut_b (
        .Clock(Clock), .ResetB(ResetB), .EnableB0(EnableB0), .EnableB1(EnableB1),
        .Enable2(Enable2), .Mode(Mode), .SelectIn(SelectIn), .ScanLast(ScanLast),
        .DwellCount(DwellCount), .DecodedOut(dec_b), .ActiveIndex(idx_b),
        .ScanWrap(wrap_b), .state_dbg(st_b)
    );

    // clock/reset block
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // model: line on/off, remaining gap cycles, cycles held on the current line
    typedef struct {
        bit on;
        int gap;
        int idx;
        int tgt;
        bit twrap;
        int age;
        bit mprev;
        bit wrap;
    } mdl_t;

    mdl_t m[2];
    int dead_of[2] = '{2, 0};

    task automatic model_reset(input int k);
        m[k].on = 0; m[k].gap = 0; m[k].idx = 0; m[k].tgt = 0;
        m[k].twrap = 0; m[k].age = 0; m[k].mprev = 0; m[k].wrap = 0;
    endtask

    task automatic model_step(input int k, input bit en, input bit mode,
                              input int sel, input int last, input int dwell);
        bit chg;
        bit go;
        chg = (mode != m[k].mprev);
        m[k].mprev = mode;
        m[k].wrap = 0;
        go = 0;
        if (!en) begin
            m[k].on = 0; m[k].gap = 0; m[k].age = 0;
        end else if (m[k].gap > 0) begin
            if (chg) begin
                m[k].tgt = mode ? 0 : sel; m[k].twrap = 0;
            end else if (!mode) begin
                m[k].tgt = sel; m[k].twrap = 0;
            end
            m[k].gap--;
            if (m[k].gap == 0) begin
                m[k].on = 1; m[k].idx = m[k].tgt; m[k].age = 0; m[k].wrap = m[k].twrap;
            end
        end else if (!m[k].on) begin
            m[k].on = 1; m[k].idx = mode ? 0 : sel; m[k].age = 0;
        end else begin
            if (chg) begin
                go = 1; m[k].tgt = mode ? 0 : sel; m[k].twrap = 0;
            end else if (!mode) begin
                if (sel != m[k].idx) begin
                    go = 1; m[k].tgt = sel; m[k].twrap = 0;
                end
            end else if (m[k].age >= dwell) begin
                m[k].twrap = (m[k].idx >= last);
                m[k].tgt = m[k].twrap ? 0 : m[k].idx + 1;
                if (m[k].tgt == m[k].idx) begin
                    m[k].age = 0; m[k].wrap = 1;
                end else begin
                    go = 1;
                end
            end else begin
                m[k].age++;
            end
            if (go) begin
                m[k].age = 0;
                if (dead_of[k] == 0) begin
                    m[k].idx = m[k].tgt; m[k].wrap = m[k].twrap;
                end else begin
                    m[k].on = 0; m[k].gap = dead_of[k];
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_dec(input int k);
        if (m[k].on) return ~(8'd1 << m[k].idx);
        return 8'hFF;
    endfunction

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endfunction

    always @(posedge Clock or negedge ResetB) begin
        if (!ResetB) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, EnableB0 && EnableB1 && !Enable2, Mode, SelectIn, ScanLast, DwellCount);
            model_step(1, EnableB0 && EnableB1 && !Enable2, Mode, SelectIn, ScanLast, DwellCount);
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge Clock) begin
        if (cmp_on) begin
            check("model_dec_a", dec_a, exp_dec(0));
            check("model_idx_a", idx_a, m[0].idx);
            check("model_wrap_a", wrap_a, m[0].wrap);
            check("model_dec_b", dec_b, exp_dec(1));
            check("model_idx_b", idx_b, m[1].idx);
            check("model_wrap_b", wrap_b, m[1].wrap);
            check("one_low_a", ($countones(~dec_a) <= 1), 1);
            check("one_low_b", ($countones(~dec_b) <= 1), 1);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic randomize_inputs();
        EnableB0 = ($urandom_range(0, 39) != 0);
        EnableB1 = ($urandom_range(0, 39) != 0);
        Enable2  = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 24) == 0) Mode = ~Mode;
        if ($urandom_range(0, 3) == 0) SelectIn = SEL_W'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) ScanLast = SEL_W'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) DwellCount = DWELL_W'($urandom_range(0, 5));
    endtask

    initial begin
        int r;
        logic [7:0] e;
        ResetB = 1'b0;
        EnableB0 = 1'b1; EnableB1 = 1'b1; Enable2 = 1'b1;
        Mode = 1'b0; SelectIn = '0; ScanLast = '0; DwellCount = '0;

        repeat (2) tick();
        check("reset_dec", dec_a, 8'hFF);
        check("reset_idx", idx_a, 0);
        check("reset_wrap", wrap_a, 0);
        tick();
        ResetB = 1'b1;
        cmp_on = 1;
        tick();
        check("disabled_dec", dec_a, 8'hFF);

        // direct decode, one-cycle latency from IDLE
        Enable2 = 1'b0; Mode = 1'b0; SelectIn = 3'd5;
        tick();
        check("direct5_dec", dec_a, 8'hDF);
        check("direct5_idx", idx_a, 5);
        check("direct5_dec_b", dec_b, 8'hDF);

        // break-before-make 5->2
        SelectIn = 3'd2;
        tick();
        check("dead1_dec", dec_a, 8'hFF);
        check("nodead_dec_b", dec_b, 8'hFB);
        check("dead1_idx", idx_a, 5);
        tick();
        check("dead2_dec", dec_a, 8'hFF);
        tick();
        check("direct2_dec", dec_a, 8'hFB);
        check("direct2_idx", idx_a, 2);

        // pending follows SelectIn mid-dead without restarting the dead count
        SelectIn = 3'd4;
        tick();
        check("middead1_dec", dec_a, 8'hFF);
        SelectIn = 3'd6;
        tick();
        check("middead2_dec", dec_a, 8'hFF);
        tick();
        check("middead_final", dec_a, 8'hBF);

        // scan 0..3, dwell 5, 2-cycle gaps; stop mid-way through second line 0
        ScanLast = 3'd3; DwellCount = 16'd4; Mode = 1'b1;
        for (int t = 0; t <= 32; t++) begin
            tick();
            r = t - 2;
            if (t < 2 || (r % 7) >= 5) e = 8'hFF;
            else e = ~(8'd1 << ((r / 7) % 4));
            check("scan_pat_dec", dec_a, e);
            check("scan_pat_wrap", wrap_a, (t == 30));
        end

        // disable mid-dwell, then re-enable in scan mode
        Enable2 = 1'b1;
        tick();
        check("disable_dec", dec_a, 8'hFF);
        check("disable_idx", idx_a, 0);
        Enable2 = 1'b0;
        tick();
        check("reenable_dec", dec_a, 8'hFE);
        check("reenable_wrap", wrap_a, 0);

        // async reset mid-drive
        tick();
        ResetB = 1'b0;
        #1;
        check("arst_drive_dec", dec_a, 8'hFF);
        check("arst_drive_dec_b", dec_b, 8'hFF);
        tick();
        ResetB = 1'b1;
        tick();
        check("release_scan_dec", dec_a, 8'hFE);
        check("release_scan_wrap", wrap_a, 0);

        // async reset mid-dead on a nonzero line
        Mode = 1'b0; SelectIn = 3'd3;
        repeat (3) tick();
        check("pre_dead_dec", dec_a, 8'hF7);
        SelectIn = 3'd5;
        tick();
        ResetB = 1'b0;
        #1;
        check("arst_dead_dec", dec_a, 8'hFF);
        check("arst_dead_idx", idx_a, 0);
        check("arst_dead_dec_b", dec_b, 8'hFF);
        tick();
        ResetB = 1'b1;
        #1;
        check("release_dec", dec_a, 8'hFF);
        tick();
        check("release_direct_dec", dec_a, 8'hDF);

        // zero dead time, one-cycle dwell: new line every cycle, no gap
        Enable2 = 1'b1;
        tick();
        Mode = 1'b1; ScanLast = 3'd7; DwellCount = 16'd0; Enable2 = 1'b0;
        for (int t = 0; t <= 16; t++) begin
            tick();
            e = ~(8'd1 << (t % 8));
            check("fast_scan_dec_b", dec_b, e);
            check("fast_scan_idx_b", idx_b, t % 8);
            check("fast_scan_wrap_b", wrap_b, (t > 0 && t % 8 == 0));
        end

        // randomized stimulus, checked each cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            if ($urandom_range(0, 499) == 0) begin
                ResetB = 1'b0;
                #2;
                ResetB = 1'b1;
            end
            tick();
        end

        tick();
        cmp_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
